auto_crc_chk: RTL and testbench
===============================

// Module: auto_crc_chk
// PURPOSE
//  Receive-side counterpart of the automated CRC generator. Samples a serial bit stream (optional 8-bit
//  address, payload, then CRC field), recomputes the CRC over address/payload and compares it with the
//  received CRC field. Configured and polled over the ICB register bus. Pulses pass/fail and raises an irq.
// PARAMETERS
//  AW      8    ICB address width (register index = icb_*adr)
//  PLW     16   payload bit-counter width (max payload 2^PLW-1 bits)
// PORTS
//  clk       in   1   single clock; all logic posedge clk
//  rst       in   1   synchronous reset, active-high
//  icb_wr    in   1   register write strobe
//  icb_wadr  in   AW  write register index
//  icb_wdat  in   32  write data
//  icb_wack  out  1   write ack = icb_wr (same cycle)
//  icb_rd    in   1   register read strobe
//  icb_radr  in   AW  read register index
//  icb_rdat  out  32  read data, combinational, 0 for unmapped index
//  icb_rack  out  1   read ack = icb_rd (same cycle)
//  data_i    in   1   serial bit in, MSB-first
//  data_vld  in   1   data_i valid this cycle; bits consumed only when 1
//  pl_o      out  1   forwarded address/payload bit (registered data_i)
//  pl_vld    out  1   pl_o valid; never high for CRC-field bits
//  chk_done  out  1   1-cycle pulse at end of frame
//  chk_ok    out  1   1-cycle pulse with chk_done when CRC matched
//  irq       out  1   level = STATUS.done & CON.ie
// BEHAVIOUR
//  Registers: 0 CON {ie[5],skipaddr[4],len[3:1],en[0]}; 1 POLY[31:0]; 2 INIT[31:0]; 3 PLEN[PLW-1:0]
//   payload bits; 4 STATUS {cfgerr[2],fail[1],done[0]} RO, write-1-to-clear; 5 RESULT computed CRC, RO.
//  Reset: all regs 0, FSM IDLE, lfsr 0, all outputs 0.
//  W = 8*len, len in 1..4. len 0 or >4 with en=1: STATUS.cfgerr=1, FSM held in IDLE.
//  FSM IDLE -> ADDR (skipaddr=1) | DATA (skipaddr=0, PLEN>0) | CRC (PLEN=0) on first data_vld while en=1;
//   that first bit is consumed as bit 0 of the entered state. ADDR: 8 bits -> DATA (or CRC if PLEN=0).
//   DATA: PLEN bits -> CRC. CRC: W bits -> DONE. DONE: one cycle, pulses chk_done/chk_ok -> IDLE.
//  len, skipaddr, POLY, INIT, PLEN latched into shadows at frame start; writes mid-frame affect next frame.
//  CON write with en=0 mid-frame: abort to IDLE next cycle, no chk_done, STATUS unchanged.
//  LFSR (W bits, Galois, MSB-first): start = INIT & mask; per DATA bit fb = lfsr[W-1]^data_i;
//   lfsr <= ((lfsr<<1) ^ (fb ? POLY : 0)) & mask. ADDR bits bypass the LFSR (skipaddr semantics).
//  CRC state: received bits shifted MSB-first into rx_crc; lfsr frozen. At DONE: RESULT <= lfsr,
//   chk_ok = (rx_crc == lfsr); STATUS.done<=1, STATUS.fail<=!chk_ok (sticky until W1C).
//  Same-cycle STATUS W1C and set: set wins.
//  pl_o/pl_vld: 1-cycle latency from data_i/data_vld in ADDR and DATA states only.
//  data_vld low mid-frame: state/counters hold, no timeout. Reset mid-frame: immediate return to reset values.
//  Back-to-back: a data_vld in the DONE cycle is ignored; next frame starts from IDLE.
// TESTING
//  T1 len=1 POLY=0x07 INIT=0 PLEN=8 payload 0x01 + CRC 0x07 -> chk_ok pulse, RESULT=0x07, STATUS=0x1
//  T2 len=2 POLY=0x1021 INIT=0xFFFF PLEN=72 "123456789" + 0x29B1 -> chk_ok; bad CRC 0x29B0 -> fail=1, irq if ie
//  T3 skipaddr=1, addr 0xA5 then T1 frame -> pass, pl_vld high 16 bits, addr bits not in CRC
//  T4 data_vld gaps of 0..5 cycles randomly inserted in T2 -> identical result and chk_done timing rel. last bit
//  T5 CON en=0 written mid-DATA -> IDLE, no chk_done; POLY write mid-frame -> current frame uses old POLY
//  T6 len=5 en=1 -> cfgerr=1, no frame accepted; STATUS W1C clears done/fail; rst mid-frame -> all zero

Source files
------------

// File: rtl/auto_crc_chk.sv
// Receive-side serial CRC checker: optional address, payload, then CRC field,
// recomputed with a Galois LFSR and compared. Configured and polled over ICB.
module auto_crc_chk #(
  parameter int unsigned AW  = 8,
  parameter int unsigned PLW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          icb_wr,
  input  logic [AW-1:0] icb_wadr,
  input  logic [31:0]   icb_wdat,
  output logic          icb_wack,
  input  logic          icb_rd,
  input  logic [AW-1:0] icb_radr,
  output logic [31:0]   icb_rdat,
  output logic          icb_rack,
  input  logic          data_i,
  input  logic          data_vld,
  output logic          pl_o,
  output logic          pl_vld,
  output logic          chk_done,
  output logic          chk_ok,
  output logic          irq
);

  localparam int unsigned CW = (PLW > 6) ? PLW : 6;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_CRC, S_DONE} state_t;

  state_t          state_q, state_d, st_in;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_in;
  logic [31:0]     lfsr_q, lfsr_d, lfsr_in;
  logic [31:0]     rx_q, rx_d, rx_in;
  logic [5:0]      con_q, con_d;
  logic [31:0]     poly_q, poly_d;
  logic [31:0]     init_q, init_d;
  logic [PLW-1:0]  plen_q, plen_d;
  logic [2:0]      status_q, status_d;
  logic [31:0]     result_q, result_d;
  logic [2:0]      len_s_q, len_s_d;
  logic            skip_s_q, skip_s_d;
  logic [31:0]     poly_s_q, poly_s_d;
  logic [PLW-1:0]  plen_s_q, plen_s_d;
  logic            pl_o_q, pl_o_d;
  logic            pl_vld_q, pl_vld_d;
  logic            done_q, done_d;
  logic            ok_q, ok_d;

  logic            len_ok, in_frame, start, abort;
  logic [2:0]      len_e;
  logic            skip_e;
  logic [31:0]     poly_e;
  logic [PLW-1:0]  plen_e;
  logic [5:0]      w_e;
  logic [4:0]      msb_e;
  logic [31:0]     mask_e;
  logic            fb;
  logic [31:0]     lfsr_nx, rx_nx;

  assign len_ok   = (con_q[3:1] != 3'd0) && (con_q[3:1] <= 3'd4);
  assign in_frame = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_CRC);
  assign start    = (state_q == S_IDLE) && con_q[0] && len_ok && data_vld;
  assign abort    = in_frame && icb_wr && (icb_wadr == AW'(0)) && !icb_wdat[0];

  // The first bit of a frame is processed with the live registers, later bits with the shadows.
  assign len_e  = start ? con_q[3:1] : len_s_q;
  assign skip_e = start ? con_q[4]   : skip_s_q;
  assign poly_e = start ? poly_q     : poly_s_q;
  assign plen_e = start ? plen_q     : plen_s_q;

  assign w_e    = {len_e, 3'b000};
  assign msb_e  = 5'(w_e - 6'd1);
  assign mask_e = 32'hFFFF_FFFF >> (6'd32 - w_e);

  always_comb begin
    st_in   = state_q;
    cnt_in  = cnt_q;
    lfsr_in = lfsr_q;
    rx_in   = rx_q;
    if (start) begin
      if (skip_e)
        st_in = S_ADDR;
      else if (plen_e != '0)
        st_in = S_DATA;
      else
        st_in = S_CRC;
      cnt_in  = '0;
      lfsr_in = init_q & mask_e;
      rx_in   = '0;
    end
  end

  assign fb      = lfsr_in[msb_e] ^ data_i;
  assign lfsr_nx = ({lfsr_in[30:0], 1'b0} ^ (fb ? poly_e : '0)) & mask_e;
  assign rx_nx   = {rx_in[30:0], data_i} & mask_e;

  always_comb begin
    con_d    = con_q;
    poly_d   = poly_q;
    init_d   = init_q;
    plen_d   = plen_q;
    status_d = status_q;
    result_d = result_q;
    len_s_d  = len_s_q;
    skip_s_d = skip_s_q;
    poly_s_d = poly_s_q;
    plen_s_d = plen_s_q;
    pl_o_d   = pl_o_q;
    pl_vld_d = 1'b0;
    done_d   = 1'b0;
    ok_d     = 1'b0;
    state_d  = st_in;
    cnt_d    = cnt_in;
    lfsr_d   = lfsr_in;
    rx_d     = rx_in;

    if (icb_wr) begin
      case (icb_wadr)
        AW'(0):  con_d    = icb_wdat[5:0];
        AW'(1):  poly_d   = icb_wdat;
        AW'(2):  init_d   = icb_wdat;
        AW'(3):  plen_d   = icb_wdat[PLW-1:0];
        AW'(4):  status_d = status_q & ~icb_wdat[2:0];
        default: ;
      endcase
    end
    if (con_q[0] && !len_ok)
      status_d[2] = 1'b1;

    if (start) begin
      len_s_d  = con_q[3:1];
      skip_s_d = con_q[4];
      poly_s_d = poly_q;
      plen_s_d = plen_q;
    end

    if (state_q == S_DONE)
      state_d = S_IDLE;

    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (data_vld) begin
      case (st_in)
        S_ADDR: begin
          pl_vld_d = 1'b1;
          pl_o_d   = data_i;
          if (cnt_in == CW'(7)) begin
            cnt_d   = '0;
            state_d = (plen_e != '0) ? S_DATA : S_CRC;
          end else begin
            cnt_d = cnt_in + CW'(1);
          end
        end
        S_DATA: begin
          pl_vld_d = 1'b1;
          pl_o_d   = data_i;
          lfsr_d   = lfsr_nx;
          if (cnt_in == CW'(plen_e) - CW'(1)) begin
            cnt_d   = '0;
            state_d = S_CRC;
          end else begin
            cnt_d = cnt_in + CW'(1);
          end
        end
        S_CRC: begin
          rx_d = rx_nx;
          if (cnt_in == CW'(w_e) - CW'(1)) begin
            cnt_d       = '0;
            state_d     = S_DONE;
            done_d      = 1'b1;
            ok_d        = (rx_nx == lfsr_in);
            result_d    = lfsr_in;
            status_d[0] = 1'b1;
            if (rx_nx != lfsr_in)
              status_d[1] = 1'b1;
          end else begin
            cnt_d = cnt_in + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lfsr_q   <= '0;
      rx_q     <= '0;
      con_q    <= '0;
      poly_q   <= '0;
      init_q   <= '0;
      plen_q   <= '0;
      status_q <= '0;
      result_q <= '0;
      len_s_q  <= '0;
      skip_s_q <= 1'b0;
      poly_s_q <= '0;
      plen_s_q <= '0;
      pl_o_q   <= 1'b0;
      pl_vld_q <= 1'b0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      rx_q     <= rx_d;
      con_q    <= con_d;
      poly_q   <= poly_d;
      init_q   <= init_d;
      plen_q   <= plen_d;
      status_q <= status_d;
      result_q <= result_d;
      len_s_q  <= len_s_d;
      skip_s_q <= skip_s_d;
      poly_s_q <= poly_s_d;
      plen_s_q <= plen_s_d;
      pl_o_q   <= pl_o_d;
      pl_vld_q <= pl_vld_d;
      done_q   <= done_d;
      ok_q     <= ok_d;
    end
  end

  always_comb begin
    icb_rdat = '0;
    case (icb_radr)
      AW'(0):  icb_rdat = {26'd0, con_q};
      AW'(1):  icb_rdat = poly_q;
      AW'(2):  icb_rdat = init_q;
      AW'(3):  icb_rdat = 32'(plen_q);
      AW'(4):  icb_rdat = {29'd0, status_q};
      AW'(5):  icb_rdat = result_q;
      default: icb_rdat = '0;
    endcase
  end

  assign icb_wack = icb_wr;
  assign icb_rack = icb_rd;
  assign pl_o     = pl_o_q;
  assign pl_vld   = pl_vld_q;
  assign chk_done = done_q;
  assign chk_ok   = ok_q;
  assign irq      = status_q[0] & con_q[5];

endmodule

// File: tb/tb_auto_crc_chk.sv
// Bench for auto_crc_chk: frame-level reference model compared every cycle,
// directed frames with known CRCs plus randomized frames with gaps.
module tb_auto_crc_chk;

  logic        clk = 1'b0;
  logic        rst;
  logic        icb_wr, icb_rd;
  logic [7:0]  icb_wadr, icb_radr;
  logic [31:0] icb_wdat, icb_rdat;
  logic        icb_wack, icb_rack;
  logic        data_i, data_vld;
  logic        pl_o, pl_vld, chk_done, chk_ok, irq;

  always #5 clk = ~clk;

  auto_crc_chk #(.AW(8), .PLW(16)) dut (
    .clk(clk), .rst(rst),
    .icb_wr(icb_wr), .icb_wadr(icb_wadr), .icb_wdat(icb_wdat), .icb_wack(icb_wack),
    .icb_rd(icb_rd), .icb_radr(icb_radr), .icb_rdat(icb_rdat), .icb_rack(icb_rack),
    .data_i(data_i), .data_vld(data_vld),
    .pl_o(pl_o), .pl_vld(pl_vld), .chk_done(chk_done), .chk_ok(chk_ok), .irq(irq)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  bit          chk_on = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc_ref(input int unsigned w, input logic [31:0] poly,
                                          input logic [31:0] init, input bit q[$]);
    logic [31:0] mask, c;
    bit top;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    c = init & mask;
    foreach (q[i]) begin
      top = c[w-1] ^ q[i];
      c = (c << 1) & mask;
      if (top) c = c ^ (poly & mask);
    end
    return c;
  endfunction

  // Reference model: register file plus frame position counted in bits.
  logic [5:0]  m_con;
  logic [31:0] m_poly, m_init, m_result;
  logic [15:0] m_plen;
  logic [2:0]  m_status;
  bit          m_active, m_done_cyc;
  int unsigned m_pos, m_w, m_fplen, m_na;
  bit          m_skip;
  logic [31:0] m_fpoly, m_finit, m_rx, m_crc;
  bit          m_bits[$];
  bit          m_abort, m_lenok, m_done_evt, m_fail_evt;
  bit          exp_pl_vld, exp_pl_o, exp_done, exp_ok;

  always @(posedge clk) begin
    exp_pl_vld = 1'b0;
    exp_done   = 1'b0;
    exp_ok     = 1'b0;
    if (rst) begin
      m_con = '0; m_poly = '0; m_init = '0; m_plen = '0; m_status = '0; m_result = '0;
      m_active = 1'b0; m_done_cyc = 1'b0; m_rx = '0; m_bits.delete();
    end else begin
      m_abort    = m_active && icb_wr && (icb_wadr == 8'd0) && !icb_wdat[0];
      m_lenok    = (m_con[3:1] >= 3'd1) && (m_con[3:1] <= 3'd4);
      m_done_evt = 1'b0;
      m_fail_evt = 1'b0;
      if (m_done_cyc) begin
        m_done_cyc = 1'b0;
      end else if (data_vld && !m_abort) begin
        if (!m_active && m_con[0] && m_lenok) begin
          m_active = 1'b1; m_pos = 0; m_rx = '0; m_bits.delete();
          m_w = 8 * int'(m_con[3:1]); m_skip = m_con[4];
          m_fplen = m_plen; m_fpoly = m_poly; m_finit = m_init;
        end
        if (m_active) begin
          m_na = m_skip ? 8 : 0;
          if (m_pos < m_na + m_fplen) begin
            exp_pl_vld = 1'b1;
            exp_pl_o   = data_i;
            if (m_pos >= m_na) m_bits.push_back(data_i);
          end else begin
            m_rx = (m_rx << 1) | 32'(data_i);
          end
          m_pos++;
          if (m_pos == m_na + m_fplen + m_w) begin
            m_crc      = crc_ref(m_w, m_fpoly, m_finit, m_bits);
            exp_done   = 1'b1;
            exp_ok     = (m_rx == m_crc);
            m_result   = m_crc;
            m_done_evt = 1'b1;
            m_fail_evt = !exp_ok;
            m_active   = 1'b0;
            m_done_cyc = 1'b1;
          end
        end
      end
      if (m_abort) m_active = 1'b0;
      if (icb_wr && icb_wadr == 8'd4) m_status = m_status & ~icb_wdat[2:0];
      if (m_con[0] && !m_lenok) m_status[2] = 1'b1;
      if (m_done_evt) m_status[0] = 1'b1;
      if (m_fail_evt) m_status[1] = 1'b1;
      if (icb_wr) begin
        case (icb_wadr)
          8'd0: m_con  = icb_wdat[5:0];
          8'd1: m_poly = icb_wdat;
          8'd2: m_init = icb_wdat;
          8'd3: m_plen = icb_wdat[15:0];
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check32("chk_done", chk_done, exp_done);
      check32("chk_ok", chk_ok, exp_ok);
      check32("pl_vld", pl_vld, exp_pl_vld);
      if (exp_pl_vld) check32("pl_o", pl_o, exp_pl_o);
      check32("irq", irq, m_status[0] & m_con[5]);
    end
  end

  // Driver tasks: entered and left just after a falling edge.
  bit pl_q[$];

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
    icb_wr = 1'b1; icb_wadr = a; icb_wdat = d;
    #1 check32("icb_wack", icb_wack, 1'b1);
    @(negedge clk);
    icb_wr = 1'b0;
  endtask

  task automatic reg_rd(input string name, input logic [7:0] a, input logic [31:0] exp);
    icb_rd = 1'b1; icb_radr = a;
    #1;
    check32(name, icb_rdat, exp);
    check32("icb_rack", icb_rack, 1'b1);
    @(negedge clk);
    icb_rd = 1'b0;
  endtask

  task automatic send_bit(input bit b, input int unsigned gmax);
    if (gmax > 0) idle($urandom_range(gmax, 0));
    data_i = b; data_vld = 1'b1;
    @(negedge clk);
    data_vld = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) pl_q.push_back(v[i]);
  endtask

  task automatic send_frame(input bit use_addr, input logic [7:0] addr, input logic [31:0] crc,
                            input int unsigned w, input int unsigned gmax);
    if (use_addr) for (int i = 7; i >= 0; i--) send_bit(addr[i], gmax);
    foreach (pl_q[i]) send_bit(pl_q[i], gmax);
    for (int i = int'(w) - 1; i >= 0; i--) send_bit(crc[i], gmax);
    idle(3);
  endtask

  task automatic cfg(input int unsigned len, input bit skip, input bit ie,
                     input logic [31:0] poly, input logic [31:0] init, input int unsigned plen);
    reg_wr(8'd1, poly);
    reg_wr(8'd2, init);
    reg_wr(8'd3, plen);
    reg_wr(8'd0, {26'd0, ie, skip, 3'(len), 1'b1});
  endtask

  task automatic status_result(input string tag);
    reg_rd({tag, "_status"}, 8'd4, {29'd0, m_status});
    reg_rd({tag, "_result"}, 8'd5, m_result);
  endtask

  int unsigned r_len, r_w, r_plen, r_gap;
  logic [31:0] r_poly, r_init, r_crc;
  bit          r_skip, r_ie;
  logic [7:0]  r_addr;

  initial begin
    rst = 1'b1; icb_wr = 1'b0; icb_rd = 1'b0; icb_wadr = '0; icb_radr = '0; icb_wdat = '0;
    data_i = 1'b0; data_vld = 1'b0;
    idle(1);
    chk_on = 1'b1;
    idle(2);
    rst = 1'b0;
    for (int a = 0; a < 7; a++) reg_rd("reset_reg", 8'(a), 32'd0);

    // T1: CRC-8 poly 0x07 over 0x01 is 0x07
    pl_q.delete(); push_byte(8'h01);
    check32("pin_crc8", crc_ref(8, 32'h07, 32'h0, pl_q), 32'h07);
    cfg(1, 1'b0, 1'b1, 32'h07, 32'h0, 8);
    send_frame(1'b0, 8'h00, 32'h07, 8, 0);
    reg_rd("t1_result", 8'd5, 32'h07);
    reg_rd("t1_status", 8'd4, 32'h1);
    reg_wr(8'd4, 32'h7);
    reg_rd("t1_w1c", 8'd4, 32'h0);

    // T2: CRC-16/CCITT-FALSE over "123456789" is 0x29B1
    pl_q.delete();
    for (int c = 8'h31; c <= 8'h39; c++) push_byte(8'(c));
    check32("pin_crc16", crc_ref(16, 32'h1021, 32'hFFFF, pl_q), 32'h29B1);
    cfg(2, 1'b0, 1'b1, 32'h1021, 32'hFFFF, 72);
    send_frame(1'b0, 8'h00, 32'h29B1, 16, 0);
    reg_rd("t2_result", 8'd5, 32'h29B1);
    reg_rd("t2_status", 8'd4, 32'h1);
    send_frame(1'b0, 8'h00, 32'h29B0, 16, 0);
    reg_rd("t2_bad_status", 8'd4, 32'h3);
    reg_wr(8'd4, 32'h7);

    // T4: same frame with random gaps
    for (int k = 0; k < 3; k++) begin
      send_frame(1'b0, 8'h00, 32'h29B1, 16, 5);
      reg_rd("t4_status", 8'd4, 32'h1);
      reg_wr(8'd4, 32'h7);
    end

    // T3: address prefix bypasses CRC
    pl_q.delete(); push_byte(8'h01);
    cfg(1, 1'b1, 1'b0, 32'h07, 32'h0, 8);
    send_frame(1'b1, 8'hA5, 32'h07, 8, 0);
    reg_rd("t3_status", 8'd4, 32'h1);
    reg_rd("t3_result", 8'd5, 32'h07);
    reg_wr(8'd4, 32'h7);

    // T5a: disable mid-payload aborts without completion
    pl_q.delete();
    for (int c = 8'h31; c <= 8'h39; c++) push_byte(8'(c));
    cfg(2, 1'b0, 1'b0, 32'h1021, 32'hFFFF, 72);
    for (int i = 0; i < 20; i++) send_bit(pl_q[i], 0);
    icb_wr = 1'b1; icb_wadr = 8'd0; icb_wdat = 32'h2; data_i = 1'b1; data_vld = 1'b1;
    @(negedge clk);
    icb_wr = 1'b0; data_vld = 1'b0;
    for (int i = 0; i < 10; i++) send_bit(1'b1, 0);
    idle(3);
    reg_rd("t5_abort_status", 8'd4, 32'h0);
    cfg(2, 1'b0, 1'b0, 32'h1021, 32'hFFFF, 72);
    send_frame(1'b0, 8'h00, 32'h29B1, 16, 0);
    reg_rd("t5_recover_status", 8'd4, 32'h1);
    reg_wr(8'd4, 32'h7);

    // T5b: POLY change mid-frame applies only to the next frame
    pl_q.delete(); push_byte(8'h01);
    cfg(1, 1'b0, 1'b0, 32'h07, 32'h0, 8);
    for (int i = 0; i < 4; i++) send_bit(pl_q[i], 0);
    reg_wr(8'd1, 32'h31);
    for (int i = 4; i < 8; i++) send_bit(pl_q[i], 0);
    for (int i = 7; i >= 0; i--) send_bit(1'(32'h07 >> i), 0);
    idle(3);
    reg_rd("t5_oldpoly_result", 8'd5, 32'h07);
    reg_rd("t5_oldpoly_status", 8'd4, 32'h1);
    send_frame(1'b0, 8'h00, 32'h31, 8, 0);
    reg_rd("t5_newpoly_result", 8'd5, 32'h31);
    reg_rd("t5_newpoly_status", 8'd4, 32'h1);
    reg_wr(8'd4, 32'h7);

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      r_len  = $urandom_range(4, 1);
      r_w    = 8 * r_len;
      r_plen = $urandom_range(24, 0);
      r_gap  = $urandom_range(3, 0);
      r_poly = $urandom;
      r_init = $urandom;
      r_skip = $urandom_range(1, 0) != 0;
      r_ie   = $urandom_range(1, 0) != 0;
      r_addr = 8'($urandom);
      pl_q.delete();
      for (int i = 0; i < int'(r_plen); i++) pl_q.push_back($urandom_range(1, 0) != 0);
      r_crc = crc_ref(r_w, r_poly, r_init, pl_q);
      if ($urandom_range(1, 0) != 0) r_crc = r_crc ^ (32'd1 << $urandom_range(r_w - 1, 0));
      cfg(r_len, r_skip, r_ie, r_poly, r_init, r_plen);
      send_frame(r_skip, r_addr, r_crc, r_w, r_gap);
      status_result("rand");
      if ($urandom_range(1, 0) != 0) reg_wr(8'd4, 32'h7);
    end
    reg_wr(8'd4, 32'h7);

    // T6: illegal length raises cfgerr and blocks frames; set beats W1C
    reg_wr(8'd0, 32'h0B);
    for (int i = 0; i < 16; i++) send_bit($urandom_range(1, 0) != 0, 0);
    idle(2);
    reg_rd("t6_cfgerr", 8'd4, 32'h4);
    reg_wr(8'd4, 32'h7);
    reg_rd("t6_cfgerr_sticky", 8'd4, 32'h4);
    reg_wr(8'd0, 32'h03);
    reg_wr(8'd4, 32'h7);
    reg_rd("t6_cleared", 8'd4, 32'h0);

    // Reset mid-frame
    pl_q.delete();
    for (int c = 8'h31; c <= 8'h39; c++) push_byte(8'(c));
    cfg(2, 1'b0, 1'b1, 32'h1021, 32'hFFFF, 72);
    for (int i = 0; i < 30; i++) send_bit(pl_q[i], 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int a = 0; a < 6; a++) reg_rd("midrst_reg", 8'(a), 32'd0);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
